jts16_scr_rom: RTL

JTS16_SCR_ROM -- requirements
Module: jts16_scr_rom

---
 rtl/jts16_pkg.sv | 20 ++
 rtl/jts16_rom_slot.sv | 37 +++
 rtl/jts16_scr_rom.sv | 107 ++++++++++
 3 files changed

// File: rtl/jts16_pkg.sv
// Shared definitions for the tile ROM arbiter: address widths and FSM encoding.
package jts16_pkg;

    localparam int MAP_AW = 14;
    localparam int SCR_AW = 17;
    localparam int SDR_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } rom_state_e;

    typedef enum logic {
        SLOT_MAP,
        SLOT_SCR
    } rom_slot_e;

endpackage

// File: rtl/jts16_rom_slot.sv
// One-entry read cache: holds the last filled address/data and flags a hit
// when the client address matches the stored one.
module jts16_rom_slot #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] data_o,
    output logic          ok_o
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            addr_q  <= waddr_i;
            data_q  <= wdata_i;
        end
    end

    // Compare is against the live client address so a change drops ok at once.
    assign ok_o   = valid_q && (addr_i == addr_q);
    assign data_o = data_q;

endmodule

// File: rtl/jts16_scr_rom.sv
// Arbitrates tilemap and tile-pixel reads onto one SDRAM port, fronting each
// client with a one-entry cache. Map requests always win over scroll pixels.
module jts16_scr_rom
    import jts16_pkg::*;
#(
    parameter logic [SDR_AW-1:0] MAP_OFFSET = 22'h00_0000,
    parameter logic [SDR_AW-1:0] SCR_OFFSET = 22'h01_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MAP_AW-1:0] map_addr,
    output logic [15:0]       map_data,
    output logic              map_ok,
    input  logic [SCR_AW-1:0] scr_addr,
    output logic [31:0]       scr_data,
    output logic              scr_ok,
    output logic [SDR_AW-1:0] sdram_addr,
    output logic              sdram_req,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [31:0]       sdram_din
);

    rom_state_e        state_q;
    rom_slot_e         slot_q;
    logic [SDR_AW-1:0] sdram_addr_q;
    logic              sdram_req_q;
    logic [SCR_AW-1:0] iss_addr_q;
    logic [31:0]       din_q;
    logic              map_we;
    logic              scr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= SLOT_MAP;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!map_ok) begin
                        slot_q       <= SLOT_MAP;
                        sdram_addr_q <= MAP_OFFSET + SDR_AW'(map_addr);
                        sdram_req_q  <= 1'b1;
                        state_q      <= ST_REQ;
                    end else if (!scr_ok) begin
                        slot_q       <= SLOT_SCR;
                        sdram_addr_q <= SCR_OFFSET + SDR_AW'(scr_addr);
                        sdram_req_q  <= 1'b1;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A coincident rdy belongs to nothing yet and is dropped.
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sdram_rdy) state_q <= ST_FILL;
                end
                ST_FILL: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Issued address and returned data only matter once the FSM says so.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE) begin
            iss_addr_q <= !map_ok ? SCR_AW'(map_addr) : scr_addr;
        end
        if (state_q == ST_WAIT && sdram_rdy) begin
            din_q <= sdram_din;
        end
    end

    assign map_we     = (state_q == ST_FILL) && (slot_q == SLOT_MAP);
    assign scr_we     = (state_q == ST_FILL) && (slot_q == SLOT_SCR);
    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;

    jts16_rom_slot #(.AW(MAP_AW), .DW(16)) u_map_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (map_addr),
        .we_i    (map_we),
        .waddr_i (iss_addr_q[MAP_AW-1:0]),
        .wdata_i (din_q[15:0]),
        .data_o  (map_data),
        .ok_o    (map_ok)
    );

    jts16_rom_slot #(.AW(SCR_AW), .DW(32)) u_scr_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr_i  (scr_addr),
        .we_i    (scr_we),
        .waddr_i (iss_addr_q),
        .wdata_i (din_q),
        .data_o  (scr_data),
        .ok_o    (scr_ok)
    );

endmodule
